// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-addressed synchronous Memory.
//
// It accepts one request at a time over a valid/ready handshake. A request is
// either narrow (DATA_W bits) or wide (2*DATA_W bits), and either a read or a
// write. The unit drives the Memory strobes for each request and signals
// completion with a one-cycle resp_valid pulse. A wide access is split into two
// word accesses, little-endian: the low half goes to addr and the high half to
// addr+1, where addr+1 wraps at the top of the address space.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake; req_ready is high only in IDLE
//   req_write, req_wide      1 = store / 1 = wide access
//   req_addr, req_wdata      word address and store data (low half only when narrow)
//   resp_valid, resp_rdata   completion pulse and the most recent load result
//   busy                     high in every state except IDLE
//   MAddr, MIn, mRead, mWrite  outputs to Memory, sampled at the rising edge
//   MOut                     Memory read data, valid the cycle after mRead
module mem_access_unit #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_wide,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  resp_valid,
    output logic [2*DATA_W-1:0]   resp_rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     MAddr,
    output logic [DATA_W-1:0]     MIn,
    output logic                  mRead,
    output logic                  mWrite,
    input  logic [DATA_W-1:0]     MOut
);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StCapLo,
        StCapHi,
        StWrLo,
        StWrHi,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*DATA_W-1:0]   wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  wide_q, wide_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [2*DATA_W-1:0]   rdata_q, rdata_d;

    // The high-half address wraps modulo 2^ADDR_W.
    logic [ADDR_W-1:0]     addr_inc;
    assign addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        wide_d     = wide_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mRead      = 1'b0;
        mWrite     = 1'b0;
        MAddr      = '0;
        MIn        = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    wide_d  = req_wide;
                    state_d = req_write ? StWrLo : StRdLo;
                end
            end
            StRdLo: begin
                mRead   = 1'b1;
                MAddr   = addr_q;
                state_d = StCapLo;
            end
            StCapLo: begin
                if (wide_q) begin
                    // The high-half read overlaps the low-half capture.
                    mRead   = 1'b1;
                    MAddr   = addr_inc;
                    lo_d    = MOut;
                    state_d = StCapHi;
                end else begin
                    rdata_d = {{DATA_W{1'b0}}, MOut};
                    state_d = StResp;
                end
            end
            StCapHi: begin
                rdata_d = {MOut, lo_q};
                state_d = StResp;
            end
            StWrLo: begin
                mWrite  = 1'b1;
                MAddr   = addr_q;
                MIn     = wdata_q[DATA_W-1:0];
                state_d = wide_q ? StWrHi : StResp;
            end
            StWrHi: begin
                mWrite  = 1'b1;
                MAddr   = addr_inc;
                MIn     = wdata_q[2*DATA_W-1:DATA_W];
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    // resp_rdata changes only when a read finishes, so the low half is staged in lo_q.
    assign resp_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
